ps2_note_arbiter: RTL

Sits between the PS/2 serial receiver and the tone generator. Consumes scan-code bytes, tracks make/break/extended prefixes, and keeps a held-key bitmap for 8 note keys. Arbitrates among held keys and presents one active note index to the audio path, with a change strobe for the display and tone logic.

---
 rtl/ps2_note_arbiter_if.sv | 27 ++
 rtl/ps2_note_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ps2_note_arbiter_if.sv
// rtl/ps2_note_arbiter_if.sv - scan-code input and note output bundle for ps2_note_arbiter
// Ports:
//   rx_data/rx_valid/rx_err : byte strobe from the PS/2 receiver (master -> slave)
//   key_held                : bitmap of the 8 note keys currently held
//   note_on/note_idx        : active note and its index
//   note_change             : one-cycle pulse when note_on or note_idx changes
//   drop_cnt                : saturating count of discarded bytes
interface ps2_note_arbiter_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] key_held;
  logic       note_on;
  logic [2:0] note_idx;
  logic       note_change;
  logic [7:0] drop_cnt;

  modport master (
    output rx_data, rx_valid, rx_err,
    input  key_held, note_on, note_idx, note_change, drop_cnt
  );

  modport slave (
    input  rx_data, rx_valid, rx_err,
    output key_held, note_on, note_idx, note_change, drop_cnt
  );
endinterface

// File: rtl/ps2_note_arbiter.sv
// rtl/ps2_note_arbiter.sv - PS/2 scan-code decoder with held-key bitmap and last-pressed-wins note arbitration
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : ps2_note_arbiter_if.slave (scan-code bytes in, note state out; all outputs registered)
module ps2_note_arbiter #(
  parameter int PREFIX_TIMEOUT = 5000000,
  parameter int CNT_W          = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  ps2_note_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0]       CODE_BRK   = 8'hF0;
  localparam logic [7:0]       CODE_EXT   = 8'hE0;
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       key_held_q, key_held_d;
  logic             note_on_q, note_on_d;
  logic [2:0]       note_idx_q, note_idx_d;
  logic             note_change_q, note_change_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             key_hit;
  logic [2:0]       key_num;
  logic [7:0]       held_after_brk;
  logic             low_any;
  logic [2:0]       low_idx;
  logic             drop_event;

  // Set-2 make codes of the eight note keys.
  always_comb begin
    key_hit = 1'b1;
    key_num = 3'd0;
    case (bus.rx_data)
      8'h1C:   key_num = 3'd0;
      8'h1B:   key_num = 3'd1;
      8'h23:   key_num = 3'd2;
      8'h2B:   key_num = 3'd3;
      8'h34:   key_num = 3'd4;
      8'h33:   key_num = 3'd5;
      8'h3B:   key_num = 3'd6;
      8'h42:   key_num = 3'd7;
      default: key_hit = 1'b0;
    endcase
  end

  // Bitmap as it would be after releasing the current key, and the lowest
  // key left in it; used to hand the note over when the active key goes up.
  always_comb begin
    held_after_brk = key_held_q & ~(8'(1) << key_num);
    low_any        = |held_after_brk;
    low_idx        = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (held_after_brk[i]) begin
        low_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    key_held_d = key_held_q;
    note_on_d  = note_on_q;
    note_idx_d = note_idx_q;
    drop_cnt_d = drop_cnt_q;
    drop_event = 1'b0;

    if (bus.rx_valid) begin
      timer_d = '0;
      if (bus.rx_err) begin
        state_d    = IDLE;
        drop_event = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.rx_data == CODE_BRK) begin
              state_d = BRK;
            end else if (bus.rx_data == CODE_EXT) begin
              state_d = EXT;
            end else if (key_hit && !key_held_q[key_num]) begin
              // Typematic repeats of a held key fall through untouched.
              key_held_d[key_num] = 1'b1;
              note_on_d           = 1'b1;
              note_idx_d          = key_num;
            end
          end
          BRK: begin
            state_d = IDLE;
            if (key_hit && key_held_q[key_num]) begin
              key_held_d = held_after_brk;
              if (note_on_q && (note_idx_q == key_num)) begin
                if (low_any) begin
                  note_idx_d = low_idx;
                end else begin
                  note_on_d = 1'b0;
                end
              end
            end
          end
          EXT: begin
            state_d = (bus.rx_data == CODE_BRK) ? EXT_BRK : IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else if (state_q != IDLE) begin
      // A byte arriving on the expiry cycle takes the branch above instead.
      if (timer_q == TIMER_LAST) begin
        state_d    = IDLE;
        timer_d    = '0;
        drop_event = 1'b1;
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end

    if (drop_event && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    note_change_d = (note_on_d != note_on_q) || (note_idx_d != note_idx_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      key_held_q    <= 8'h00;
      note_on_q     <= 1'b0;
      note_idx_q    <= 3'd0;
      note_change_q <= 1'b0;
      drop_cnt_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      key_held_q    <= key_held_d;
      note_on_q     <= note_on_d;
      note_idx_q    <= note_idx_d;
      note_change_q <= note_change_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign bus.key_held    = key_held_q;
  assign bus.note_on     = note_on_q;
  assign bus.note_idx    = note_idx_q;
  assign bus.note_change = note_change_q;
  assign bus.drop_cnt    = drop_cnt_q;

endmodule
